rr_mux_sel: RTL and testbench

//  Upstream select/capture stage for mux4. Arbitrates four requesting sources round-robin,

---
 rtl/rr_mux_sel.sv | 141 ++++++++++++++
 tb/tb_rr_mux_sel.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_sel.sv
// rr_mux_sel: select/capture stage in front of a 4-input mux (mux4).
//
// Four sources raise req[i] when their word is present on mux4 input d<i>.
// The block picks one requester, drives the mux4 select s, captures the
// mux4 output on the following cycle and presents it downstream with a
// valid/ready handshake. Exactly one word is moved per grant, and each
// grant takes at least three cycles (IDLE -> CAPT -> OUT).
//
// Ports
//   clk        in   1   clock; all state updates on the rising edge
//   rst        in   1   synchronous reset, active-high
//   req        in   4   per-source request (bit i = mux4 input d<i>)
//   ack        out  4   one-hot, single-cycle pulse: source word captured
//   s          out  2   registered select to mux4 .s
//   mux_y      in   W   mux4 .y (combinational through mux4)
//   out_data   out  W   captured word
//   out_ch     out  2   source index of out_data
//   out_valid  out  1   out_data / out_ch valid
//   out_ready  in   1   downstream accepts when out_valid & out_ready
//
// Build option
//   MUXSEL_FIXED_PRIO_EN  when defined, arbitration is fixed priority
//                         (source 0 highest) and the rotation pointer is
//                         held at 0. Otherwise round-robin.

module rr_mux_sel #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  output logic [3:0]   ack,
  output logic [1:0]   s,
  input  logic [W-1:0] mux_y,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_ch,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     s_q, s_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [1:0]     out_ch_q, out_ch_d;
  logic           out_valid_q, out_valid_d;
  logic [3:0]     ack_q, ack_d;

  // First set request bit scanning p, p+1, ... with 2-bit wrap. Scanning
  // in descending offset order lets the smallest offset overwrite last.
  // With the pointer pinned at 0 this is plain lowest-index priority, so
  // both arbitration modes share this function.
  function automatic logic [1:0] pick_winner(input logic [3:0] r,
                                             input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  // State register and all datapath/control flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      s_q         <= 2'd0;
      out_data_q  <= '0;
      out_ch_q    <= 2'd0;
      out_valid_q <= 1'b0;
      ack_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      s_q         <= s_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req != 4'd0) state_d = CAPT;
      CAPT:    state_d = OUT;
      OUT:     if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register updates per state. req is only looked at in IDLE; the word
  // captured in CAPT always comes from the select latched on entry.
  always_comb begin
    ptr_d       = ptr_q;
    s_d         = s_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ack_d       = 4'd0;
    unique case (state_q)
      IDLE: begin
        if (req != 4'd0) s_d = pick_winner(req, ptr_q);
      end
      CAPT: begin
        out_data_d  = mux_y;
        out_ch_d    = s_q;
        out_valid_d = 1'b1;
        ack_d       = 4'b0001 << s_q;
`ifdef MUXSEL_FIXED_PRIO_EN
        ptr_d       = 2'd0;
`else
        // Served source drops behind every other requester.
        ptr_d       = s_q + 2'd1;
`endif
      end
      OUT: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign ack       = ack_q;
  assign s         = s_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_sel.sv
module tb_rr_mux_sel;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [1:0]   s;
  logic [W-1:0] mux_y;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic         out_valid;
  logic         out_ready;

  logic [W-1:0] dval [4];

  int n_assert;
  int n_fail;

  rr_mux_sel #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ack       (ack),
    .s         (s),
    .mux_y     (mux_y),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // mux4 stand-in
  assign mux_y = dval[s];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    req = 4'd0;
    out_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) until out_valid is seen just after an edge.
  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] ch_rr;
    logic [1:0] ch_fp;
  } vec_t;

  // Reference model state (transaction-level: phase 0 waiting, 1 selected, 2 presenting)
  int         m_phase;
  int         m_ptr;
  int         m_s;
  int         m_data;
  int         m_ch;
  int         m_valid;
  logic [3:0] m_ack;

  task automatic model_reset;
    m_phase = 0; m_ptr = 0; m_s = 0; m_data = 0; m_ch = 0; m_valid = 0; m_ack = 4'd0;
  endtask

  task automatic model_step(input logic r_rst, input logic [3:0] r_req, input logic r_rdy);
    if (r_rst) begin
      model_reset();
      return;
    end
    m_ack = 4'd0;
    if (m_phase == 0) begin
      if (r_req != 4'd0) begin
        for (int k = 0; k < 4; k++) begin
          if (r_req[(m_ptr + k) % 4]) begin
            m_s = (m_ptr + k) % 4;
            break;
          end
        end
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data  = int'(dval[m_s]);
      m_ch    = m_s;
      m_valid = 1;
      m_ack   = 4'(1 << m_s);
`ifdef MUXSEL_FIXED_PRIO_EN
      m_ptr   = 0;
`else
      m_ptr   = (m_s + 1) % 4;
`endif
      m_phase = 2;
    end else begin
      if (r_rdy) begin
        m_valid = 0;
        m_phase = 0;
      end
    end
  endtask

  vec_t vecs [12];

  initial begin
    logic [1:0] exp_ch;
    int         n;
    logic       r_rst;
    logic [3:0] r_req;
    logic       r_rdy;

    n_assert = 0;
    n_fail   = 0;
    dval[0] = 4'd2; dval[1] = 4'd4; dval[2] = 4'd6; dval[3] = 4'd9;

    // {req, expected channel round-robin, expected channel fixed priority}
    vecs[0]  = '{4'b0001, 2'd0, 2'd0};
    vecs[1]  = '{4'b1111, 2'd1, 2'd0};
    vecs[2]  = '{4'b1111, 2'd2, 2'd0};
    vecs[3]  = '{4'b1111, 2'd3, 2'd0};
    vecs[4]  = '{4'b1111, 2'd0, 2'd0};
    vecs[5]  = '{4'b0010, 2'd1, 2'd1};
    vecs[6]  = '{4'b1010, 2'd3, 2'd1};
    vecs[7]  = '{4'b1010, 2'd1, 2'd1};
    vecs[8]  = '{4'b0100, 2'd2, 2'd2};
    vecs[9]  = '{4'b0011, 2'd0, 2'd0};
    vecs[10] = '{4'b1001, 2'd3, 2'd0};
    vecs[11] = '{4'b1100, 2'd2, 2'd2};

    rst = 1'b1;
    req = 4'd0;
    out_ready = 1'b0;
    do_reset();

    // Reset state
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s",     {30'd0, s},         32'd0);
    check("rst_ack",   {28'd0, ack},       32'd0);
    check("rst_data",  {28'd0, out_data},  32'd0);
    check("rst_ch",    {30'd0, out_ch},    32'd0);

    // Single request: latency and one-cycle ack
    @(negedge clk);
    req = 4'b0001;
    out_ready = 1'b1;
    tick();
    check("lat_s_after_sample", {30'd0, s}, 32'd0);
    check("lat_valid_early",    {31'd0, out_valid}, 32'd0);
    check("lat_ack_early",      {28'd0, ack}, 32'd0);
    tick();
    req = 4'd0;
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data",  {28'd0, out_data},  32'd2);
    check("lat_ch",    {30'd0, out_ch},    32'd0);
    check("lat_ack",   {28'd0, ack},       32'b0001);
    tick();
    check("lat_valid_drop", {31'd0, out_valid}, 32'd0);
    check("lat_ack_drop",   {28'd0, ack},       32'd0);

    // Backpressure: word 6 from source 2 held for 5 cycles
    @(negedge clk);
    out_ready = 1'b0;
    req = 4'b0100;
    wait_valid("bp");
    req = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data",  {28'd0, out_data},  32'd6);
      check("bp_ch",    {30'd0, out_ch},    32'd2);
      check("bp_ack",   {28'd0, ack},       32'd0);
      check("bp_s",     {30'd0, s},         32'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    check("bp_release", {31'd0, out_valid}, 32'd0);

    // Reset while presenting a word
    @(negedge clk);
    out_ready = 1'b0;
    req = 4'b1000;
    wait_valid("rstout");
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    tick();
    check("rstout_valid", {31'd0, out_valid}, 32'd0);
    check("rstout_s",     {30'd0, s},         32'd0);
    check("rstout_ack",   {28'd0, ack},       32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    wait_valid("rstout_next");
    check("rstout_next_ch", {30'd0, out_ch}, 32'd0);
    req = 4'd0;
    tick();

    // Table-driven grants from a fresh reset
    do_reset();
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      req = vecs[v].req;
      out_ready = 1'b1;
`ifdef MUXSEL_FIXED_PRIO_EN
      exp_ch = vecs[v].ch_fp;
`else
      exp_ch = vecs[v].ch_rr;
`endif
      n = 0;
      while (ack === 4'd0 && n < 12) begin
        tick();
        n++;
      end
      req = 4'd0;
      check($sformatf("tbl%0d_ack", v),   {28'd0, ack},      32'(4'b0001 << exp_ch));
      check($sformatf("tbl%0d_ch", v),    {30'd0, out_ch},   {30'd0, exp_ch});
      check($sformatf("tbl%0d_data", v),  {28'd0, out_data}, {28'd0, dval[exp_ch]});
      check($sformatf("tbl%0d_valid", v), {31'd0, out_valid}, 32'd1);
      check($sformatf("tbl%0d_s", v),     {30'd0, s},        {30'd0, exp_ch});
      tick();
      check($sformatf("tbl%0d_done", v),  {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      r_rst = rst; r_req = req; r_rdy = out_ready;
      @(posedge clk);
      model_step(r_rst, r_req, r_rdy);
      #1;
      check("rnd_s",     {30'd0, s},         32'(m_s));
      check("rnd_valid", {31'd0, out_valid}, 32'(m_valid));
      check("rnd_ack",   {28'd0, ack},       {28'd0, m_ack});
      if (m_valid != 0) begin
        check("rnd_data", {28'd0, out_data}, 32'(m_data));
        check("rnd_ch",   {30'd0, out_ch},   32'(m_ch));
      end
    end
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
